// File: rtl/fcvt_if.sv
// fcvt_if: request/response bundle between the FPU issue logic and fcvt.
// The master drives requests and consumes results; the slave is the converter.
interface fcvt_if;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        ovf;

    modport master (
        output in_valid,
        output op,
        output x,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  op,
        input  x,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output ovf
    );
endinterface

// File: rtl/fcvt.sv
// fcvt: two-stage int32 <-> single-precision converter, round to nearest even.
// Stage 1 unpacks the operand (magnitude, leading zeros, exponent); stage 2
// normalises, rounds and registers the result. One global enable stalls both
// stages together whenever a held result is not being consumed.
module fcvt (
    input logic    clk,
    input logic    rstn,
    fcvt_if.slave  bus
);
    logic        en;

    logic        s1_valid;
    logic        s1_op;
    logic        s1_sign;
    logic [31:0] s1_mag;
    logic [7:0]  s1_exp;
    logic [5:0]  s1_lz;

    logic [31:0] in_mag;
    logic [5:0]  in_lz;

    logic [31:0] norm;
    logic [23:0] it_rnd;
    logic        it_up;
    logic [7:0]  it_exp;
    logic [4:0]  ft_sh;
    logic [54:0] ft_wide;
    logic        ft_up;
    logic [31:0] ft_mag;
    logic [31:0] res_y;
    logic        res_ovf;

    logic        out_valid_q;
    logic [31:0] y_q;
    logic        ovf_q;

    function automatic logic [5:0] count_lz(input logic [31:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 6'd1;
            end
        end
        return n;
    endfunction

    assign en            = ~out_valid_q | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.ovf       = ovf_q;

    // Unpack the incoming operand: |x| and its leading zeros for itof, the significand with hidden bit for ftoi.
    always_comb begin
        in_mag = 32'd0;
        in_lz  = 6'd0;
        if (!bus.op) begin
            in_mag = bus.x[31] ? (32'd0 - bus.x) : bus.x;
            in_lz  = count_lz(in_mag);
        end else begin
            in_mag = {8'd0, (bus.x[30:23] != 8'd0), bus.x[22:0]};
        end
    end

    // Stage 1 register: captures the unpacked operand whenever the pipe advances.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_op    <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= 32'd0;
            s1_exp   <= 8'd0;
            s1_lz    <= 6'd0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_op    <= bus.op;
            s1_sign  <= bus.x[31];
            s1_mag   <= in_mag;
            s1_exp   <= bus.x[30:23];
            s1_lz    <= in_lz;
        end
    end

    // Normalise and round both directions, then pick the result for the stage-1 op.
    always_comb begin
        // itof: MSB of the normalised magnitude sits at bit 31 (it is 0 only for x == 0)
        norm   = s1_mag << s1_lz;
        it_up  = norm[7] & ((|norm[6:0]) | norm[8]);
        it_rnd = {1'b0, norm[30:8]} + {23'd0, it_up};
        it_exp = 8'(9'd158 - {3'd0, s1_lz} + {8'd0, it_rnd[23]});

        // ftoi: place the significand 157-e to the right of bit 54 so the
        // integer part lands in [54:24]; e = 126 (shift 31) rounds 0.5..1 here too
        ft_sh   = 5'(8'd157 - s1_exp);
        ft_wide = {s1_mag[23:0], 31'd0} >> ft_sh;
        ft_up   = ft_wide[23] & ((|ft_wide[22:0]) | ft_wide[24]);
        ft_mag  = {1'b0, ft_wide[54:24]} + {31'd0, ft_up};

        res_y   = 32'd0;
        res_ovf = 1'b0;
        if (!s1_op) begin
            if (norm[31]) begin
                res_y = {s1_sign, it_exp, it_rnd[22:0]};
            end
        end else begin
            if (s1_exp >= 8'd158) begin
                if (s1_sign && (s1_exp == 8'd158) && (s1_mag[22:0] == 23'd0)) begin
                    // exactly -2^31 is representable, so no saturation
                    res_y = 32'h8000_0000;
                end else begin
                    res_y   = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    res_ovf = 1'b1;
                end
            end else if (s1_exp >= 8'd126) begin
                res_y = s1_sign ? (32'd0 - ft_mag) : ft_mag;
            end
        end
    end

    // Stage 2 output register: holds the result steady until the consumer takes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            y_q         <= 32'd0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            out_valid_q <= s1_valid;
            y_q         <= res_y;
            ovf_q       <= res_ovf;
        end
    end
endmodule

// File: tb/tb_fcvt.sv
// tb_fcvt: scoreboard bench for fcvt. Requests push the reference result into
// a queue; a negedge monitor compares every presented output with the queue head.
module tb_fcvt;
    typedef struct {
        logic [31:0] y;
        logic        ovf;
        int          acc;
        bit          lat_chk;
    } exp_t;

    logic clk;
    logic rstn;
    fcvt_if intf ();

    fcvt dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (intf)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   rand_ready = 0;
    bit   front_seen = 0;
    exp_t sb[$];
    exp_t mon_e;

    localparam logic [31:0] ITOF_X [6] = '{32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0100_0001, 32'd0, 32'h8000_0000};
    localparam logic [31:0] ITOF_Y [6] = '{32'h3F80_0000, 32'hBF80_0000, 32'h4F00_0000, 32'h4B80_0000, 32'h0000_0000, 32'hCF00_0000};
    localparam logic [31:0] RND_X [5] = '{32'h4020_0000, 32'h4060_0000, 32'hBF00_0000, 32'h3F40_0000, 32'hC020_0000};
    localparam logic [31:0] RND_Y [5] = '{32'd2, 32'd4, 32'd0, 32'd1, 32'hFFFF_FFFE};
    localparam logic [31:0] SAT_X [4] = '{32'h4F00_0000, 32'hCF00_0000, 32'hFF80_0000, 32'h7FC0_0000};
    localparam logic [31:0] SAT_Y [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    localparam logic        SAT_O [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic        BP_OP [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [31:0] BP_X  [4] = '{32'd7, 32'h4060_0000, 32'hFFFF_FFFD, 32'hBF40_0000};
    localparam logic [31:0] BP_Y  [4] = '{32'h40E0_0000, 32'd4, 32'hC040_0000, 32'hFFFF_FFFF};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_ready) intf.out_ready = ($urandom_range(0, 4) != 0);
    end

    // int32 -> float: exact magnitude, find the top bit, round the dropped bits to nearest even
    function automatic logic [31:0] ref_itof(input logic [31:0] x);
        longint m, q, rem, half;
        int     e, k;
        if (x == 32'd0) return 32'd0;
        m = longint'({32'd0, x});
        if (x[31]) m = 64'sd4294967296 - m;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            k    = e - 23;
            q    = m >> k;
            rem  = m - (q << k);
            half = 64'sd1 << (k - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'sd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        return {x[31], 8'(e + 127), q[22:0]};
    endfunction

    // float -> int32: value = sig * 2^(e-150), rounded to nearest even, saturated to the int32 range
    task automatic ref_ftoi(input logic [31:0] x, output logic [31:0] y, output logic ovf);
        longint sig, m, q, rem, half, v;
        int     ex, k;
        ex  = int'(x[30:23]);
        sig = longint'({40'd1, x[22:0]});
        y   = 32'd0;
        ovf = 1'b0;
        if (ex == 0) return;
        if (ex == 255 || ex >= 190) begin
            y   = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            ovf = 1'b1;
            return;
        end
        if (ex >= 150) begin
            m = sig << (ex - 150);
        end else begin
            k = 150 - ex;
            if (k > 25) begin
                m = 0;
            end else begin
                q    = sig >> k;
                rem  = sig - (q << k);
                half = 64'sd1 << (k - 1);
                if (rem > half || (rem == half && q[0])) q = q + 1;
                m = q;
            end
        end
        v = x[31] ? -m : m;
        if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
            y   = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            ovf = 1'b1;
        end else begin
            y = 32'(v);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // drive one request until accepted, then push the given expected response
    task automatic apply_expect(input logic op, input logic [31:0] x, input logic [31:0] ey,
                                input logic eovf, input bit lat_chk);
        exp_t e;
        int   budget;
        bit   done;
        budget = 0;
        done   = 0;
        @(posedge clk);
        #1;
        intf.in_valid = 1'b1;
        intf.op       = op;
        intf.x        = x;
        while (!done && budget < 100) begin
            @(negedge clk);
            if (intf.in_ready) begin
                e.y       = ey;
                e.ovf     = eovf;
                e.acc     = cyc;
                e.lat_chk = lat_chk;
                sb.push_back(e);
                done = 1;
            end else begin
                budget++;
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: op=%0d x=%h not accepted in 100 cycles", op, x);
        end
    endtask

    task automatic apply_stimulus(input logic op, input logic [31:0] x);
        logic [31:0] ey;
        logic        eovf;
        if (!op) begin
            ey   = ref_itof(x);
            eovf = 1'b0;
        end else begin
            ref_ftoi(x, ey, eovf);
        end
        apply_expect(op, x, ey, eovf, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            intf.in_valid = 1'b0;
        end
    endtask

    // wait (bounded) for every expected response to have been consumed
    task automatic check_output(input string tag, input int budget);
        int w;
        w = 0;
        while (sb.size() != 0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: %0d results outstanding, required 0", tag, sb.size());
        end
    endtask

    // Monitor: compare every presented output with the scoreboard head; pop on transfer.
    always @(negedge clk) begin
        if (rstn && intf.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: y=%h ovf=%0d with nothing outstanding", intf.y, intf.ovf);
            end else begin
                mon_e = sb[0];
                if (!front_seen) begin
                    front_seen = 1;
                    if (mon_e.lat_chk) begin
                        checks++;
                        if (cyc != mon_e.acc + 2) begin
                            errors++;
                            $display("[TB] FAIL latency: result seen %0d cycles after accept, required 2", cyc - mon_e.acc);
                        end
                    end
                end
                checks++;
                if (intf.y !== mon_e.y || intf.ovf !== mon_e.ovf) begin
                    errors++;
                    $display("[TB] FAIL result: got y=%h ovf=%0d expected y=%h ovf=%0d",
                             intf.y, intf.ovf, mon_e.y, mon_e.ovf);
                end
                if (!intf.out_ready) begin
                    checks++;
                    if (intf.in_ready !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL stall_in_ready: got %0d expected 0", intf.in_ready);
                    end
                end else begin
                    void'(sb.pop_front());
                    front_seen = 0;
                end
            end
        end
    end

    initial begin
        intf.in_valid  = 1'b0;
        intf.op        = 1'b0;
        intf.x         = 32'd0;
        intf.out_ready = 1'b1;
        rstn           = 1'b1;
        #2 rstn = 1'b0;
        #10;
        check_val("reset_out_valid", {31'd0, intf.out_valid}, 32'd0);
        check_val("reset_y", intf.y, 32'd0);
        check_val("reset_ovf", {31'd0, intf.ovf}, 32'd0);
        check_val("reset_in_ready", {31'd0, intf.in_ready}, 32'd1);
        @(negedge clk);
        #1 rstn = 1'b1;

        $display("[TB] itof sequence");
        for (int i = 0; i < 6; i++) apply_expect(1'b0, ITOF_X[i], ITOF_Y[i], 1'b0, 1);
        idle(1);
        check_output("itof_seq", 20);

        $display("[TB] ftoi rounding and saturation");
        for (int i = 0; i < 5; i++) apply_expect(1'b1, RND_X[i], RND_Y[i], 1'b0, 1);
        for (int i = 0; i < 4; i++) apply_expect(1'b1, SAT_X[i], SAT_Y[i], SAT_O[i], 1);
        idle(1);
        check_output("ftoi_dir", 20);

        $display("[TB] backpressure");
        fork
            begin
                for (int i = 0; i < 4; i++) apply_expect(BP_OP[i], BP_X[i], BP_Y[i], 1'b0, 0);
                idle(1);
            end
            begin
                int w;
                w = 0;
                while (!intf.out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                if (!intf.out_valid) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL bp_first_valid: out_valid got 0 expected 1 within 20 cycles");
                end
                @(posedge clk);
                #1 intf.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 intf.out_ready = 1'b1;
            end
        join
        check_output("backpressure", 20);

        $display("[TB] reset mid-operation");
        apply_expect(1'b0, 32'd5, 32'h40A0_0000, 1'b0, 0);
        apply_expect(1'b1, 32'h4020_0000, 32'd2, 1'b0, 0);
        @(posedge clk);
        #1 intf.in_valid = 1'b0;
        #1;
        check_val("rst_pre_valid", {31'd0, intf.out_valid}, 32'd1);
        rstn = 1'b0;
        #1;
        check_val("rst_out_valid", {31'd0, intf.out_valid}, 32'd0);
        check_val("rst_in_ready", {31'd0, intf.in_ready}, 32'd1);
        sb.delete();
        front_seen = 0;
        @(posedge clk);
        @(negedge clk);
        #1 rstn = 1'b1;
        check_val("rst_release_in_ready", {31'd0, intf.in_ready}, 32'd1);
        idle(6);
        check_val("rst_no_stale", {31'd0, intf.out_valid}, 32'd0);

        $display("[TB] random differential");
        rand_ready = 1;
        for (int i = 0; i < 10000; i++) begin
            logic        rop;
            logic [31:0] rx;
            rop = 1'($urandom_range(0, 1));
            if (!rop) begin
                case ($urandom_range(0, 9))
                    0: rx = $urandom;
                    1: begin
                        case ($urandom_range(0, 4))
                            0: rx = 32'd0;
                            1: rx = 32'd1;
                            2: rx = 32'hFFFF_FFFF;
                            3: rx = 32'h8000_0000;
                            default: rx = 32'h7FFF_FFFF;
                        endcase
                    end
                    default: begin
                        rx = $urandom >> $urandom_range(0, 31);
                        if ($urandom_range(0, 1) == 1) rx = 32'd0 - rx;
                    end
                endcase
            end else begin
                case ($urandom_range(0, 9))
                    0: rx = $urandom;
                    1: begin
                        case ($urandom_range(0, 4))
                            0: rx = 32'hCF00_0000;
                            1: rx = 32'h7F80_0000;
                            2: rx = 32'hFFC0_0001;
                            3: rx = 32'h8000_0000;
                            default: rx = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
                        endcase
                    end
                    default: rx = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 162)), 23'($urandom)};
                endcase
            end
            apply_stimulus(rop, rx);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(1);
        @(posedge clk);
        #2;
        rand_ready = 0;
        intf.out_ready = 1'b1;
        check_output("random", 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
